ifu_prefetch: RTL

- Parametrised instruction-fetch unit with a prefetch buffer, for the next-generation processor core.
- Fetches sequentially from a synchronous-read program memory and buffers fetched words in a DEPTH-entry FIFO, each word tagged with its PC.
- Hands words to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight words. The current single-cycle core has none of this: it fetches combinationally with no buffering or backpressure.

---
 rtl/ifu_prefetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: sequential fetch from synchronous-read program memory
// into a PC-tagged prefetch FIFO, with redirect/flush and valid/ready delivery.
module ifu_prefetch #(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_BITS = 9,
    parameter int                   DEPTH     = 4,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_en,
    output logic [ADDR_BITS-1:0]        imem_addr,
    input  logic [WIDTH-1:0]            imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_BITS-1:0]        redirect_pc,
    output logic                        instr_valid,
    output logic [WIDTH-1:0]            instr,
    output logic [ADDR_BITS-1:0]        instr_pc,
    input  logic                        instr_ready,
    output logic [$clog2(DEPTH):0]      fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_BITS-1:0] req_pc_q, req_pc_d;
    logic                 inflight_q, inflight_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     data_mem_q [DEPTH];
    logic [ADDR_BITS-1:0] pc_mem_q   [DEPTH];

    logic                 pop;
    logic                 push;
    logic                 issue;
    logic [CW:0]          occupancy;

    assign instr_valid = reset && (count_q != '0);
    assign pop         = instr_valid && instr_ready;
    // A response landing in a redirect cycle belongs to the old stream.
    assign push        = inflight_q && !redirect_valid;

    // Buffered words plus the one still in flight, less the one leaving now.
    assign occupancy   = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue       = reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));

    assign imem_en     = issue;
    assign imem_addr   = reset ? fetch_pc_q : RESET_PC;
    assign instr       = instr_valid ? data_mem_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]   : '0;
    assign fifo_count  = reset ? count_q : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_BITS'(1);
            req_pc_d   = fetch_pc_q;
        end
        // Flush wins over everything; a same-cycle pop has already been accepted.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        if (push) begin
            data_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule
